// File: rtl/btn_pkg.sv
// btn_pkg: shared constants, types and helpers for button_conditioner.
// The optional auto-repeat feature is selected by defining BTN_REPEAT_EN.
package btn_pkg;

  localparam int NUM_BTN = 4;

  // Direction indices; a higher index also wins arbitration.
  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  // Default timing: 5 ms debounce, 0.5 s first repeat, 0.2 s repeat period at 100 MHz.
  localparam int DEF_DB_CYCLES     = 500_000;
  localparam int DEF_REPEAT_DELAY  = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 20_000_000;

  // Auto-repeat slot: idle, waiting for the first repeat, or repeating periodically.
  typedef enum logic [1:0] {
    REP_IDLE  = 2'd0,
    REP_FIRST = 2'd1,
    REP_NEXT  = 2'd2
  } rep_state_t;

  // Width of a counter that must reach count-1; never narrower than one bit.
  function automatic int cnt_width(input int count);
    return (count < 2) ? 1 : $clog2(count);
  endfunction

  // One-hot direction vector for a direction index.
  function automatic logic [NUM_BTN-1:0] dir_onehot(input logic [1:0] idx);
    logic [NUM_BTN-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: conditions one raw push-button pin.
// Two-flop synchronizer, debounce counter holding the accepted level, and a
// one-cycle rise strobe on each accepted 0->1 transition. The accepted level
// is exported only when BTN_REPEAT_EN is defined (the repeat logic needs it).
module debounce_cell
  import btn_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic clr,
  input  logic pin,
`ifdef BTN_REPEAT_EN
  output logic stable,
`endif
  output logic rise
);

  localparam int CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          s;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= pin;
      s     <= sync1;
    end
  end

  // Accept a new level only after DB_CYCLES consecutive disagreeing samples;
  // any agreeing sample restarts the count, and the count never passes its end.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (s == level) begin
      cnt <= '0;
    end else if (cnt >= CNT_LAST) begin
      level <= s;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Previous accepted level, for edge detection.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  // Press strobe: accepted level just went high; releases give nothing.
  assign rise = level & ~level_d;

`ifdef BTN_REPEAT_EN
  assign stable = level;
`endif

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: turns four raw, bouncing push-button pins into
// mutually exclusive one-cycle direction pulses plus a matching en strobe.
// Priority on simultaneous presses: up > down > left > right; losers dropped.
// Define BTN_REPEAT_EN to re-emit a held button's pulse after REPEAT_DELAY
// cycles and then every REPEAT_CYCLES cycles.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
`ifdef BTN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
`endif
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic en
);

  logic [NUM_BTN-1:0] pins;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] win_vec;
  logic [NUM_BTN-1:0] next_dir;

  assign pins[DIR_UP]    = btn_up;
  assign pins[DIR_DOWN]  = btn_down;
  assign pins[DIR_LEFT]  = btn_left;
  assign pins[DIR_RIGHT] = btn_right;

`ifdef BTN_REPEAT_EN
  logic [NUM_BTN-1:0] stable;
`endif

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
    debounce_cell #(
      .DB_CYCLES(DB_CYCLES)
    ) u_cell (
      .clk   (clk),
      .clr   (clr),
      .pin   (pins[i]),
`ifdef BTN_REPEAT_EN
      .stable(stable[i]),
`endif
      .rise  (rise[i])
    );
  end

  // Fixed-priority arbitration: the highest-index rising button wins.
  always_comb begin
    win_vec = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (rise[i]) begin
        win_vec    = '0;
        win_vec[i] = 1'b1;
      end
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] CYCLES_LAST = RW'(REPEAT_CYCLES - 1);

  logic          any_rise;
  logic [1:0]    win_idx;
  rep_state_t    rep_state;
  rep_state_t    rep_state_nxt;
  logic [1:0]    rep_dir;
  logic [1:0]    rep_dir_nxt;
  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_cnt_nxt;
  logic          rep_fire;

  assign any_rise = |rise;

  // Index of the arbitration winner, to seed the repeat slot.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (win_vec[i]) begin
        win_idx = 2'(i);
      end
    end
  end

  // Repeat slot state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rep_state <= REP_IDLE;
      rep_dir   <= '0;
      rep_cnt   <= '0;
    end else begin
      rep_state <= rep_state_nxt;
      rep_dir   <= rep_dir_nxt;
      rep_cnt   <= rep_cnt_nxt;
    end
  end

  // Repeat slot next state: a new press always takes the slot and restarts the
  // timer; a release of the slot's button frees it; otherwise count to the
  // first-repeat or periodic-repeat terminal value and fire.
  always_comb begin
    rep_state_nxt = rep_state;
    rep_dir_nxt   = rep_dir;
    rep_cnt_nxt   = rep_cnt;
    rep_fire      = 1'b0;
    if (any_rise) begin
      rep_state_nxt = REP_FIRST;
      rep_dir_nxt   = win_idx;
      rep_cnt_nxt   = '0;
    end else begin
      case (rep_state)
        REP_FIRST, REP_NEXT: begin
          if (!stable[rep_dir]) begin
            rep_state_nxt = REP_IDLE;
            rep_cnt_nxt   = '0;
          end else if (rep_cnt >= ((rep_state == REP_FIRST) ? DELAY_LAST : CYCLES_LAST)) begin
            rep_fire      = 1'b1;
            rep_state_nxt = REP_NEXT;
            rep_cnt_nxt   = '0;
          end else begin
            rep_cnt_nxt = rep_cnt + RW'(1);
          end
        end
        default: begin
          rep_state_nxt = REP_IDLE;
          rep_cnt_nxt   = '0;
        end
      endcase
    end
  end
`endif

  // Direction to emit next cycle: a new press, else (with repeat) a repeat pulse.
  always_comb begin
    next_dir = win_vec;
`ifdef BTN_REPEAT_EN
    if (rep_fire) begin
      next_dir = dir_onehot(rep_dir);
    end
`endif
  end

  // Registered one-cycle outputs; en mirrors any direction pulse.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      up    <= 1'b0;
      down  <= 1'b0;
      left  <= 1'b0;
      right <= 1'b0;
      en    <= 1'b0;
    end else begin
      up    <= next_dir[DIR_UP];
      down  <= next_dir[DIR_DOWN];
      left  <= next_dir[DIR_LEFT];
      right <= next_dir[DIR_RIGHT];
      en    <= |next_dir;
    end
  end

endmodule
